// File: rtl/sample_rate_reducer_pkg.sv
// Shared constants and types for the sample-rate reducer and its sample_clk-driven neighbours.
package sample_rate_reducer_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned MV_SCALE      = 4;
    localparam int unsigned CV_MAX_MV     = 5000;
    localparam int unsigned CV_MAX_COUNTS = CV_MAX_MV * MV_SCALE;
    localparam int unsigned DEF_PSHIFT    = 10;
    localparam int unsigned DEF_PMAX      = 20;

    typedef enum logic {
        HOLD    = 1'b0,
        CAPTURE = 1'b1
    } srr_state_e;

endpackage

// File: rtl/sample_rate_reducer_if.sv
// Four-channel sample bus with jack-detect; master drives samples, slave returns processed ones.
interface sample_rate_reducer_if
    import sample_rate_reducer_pkg::*;
#(
    parameter int unsigned W = SAMPLE_W
);

    logic                sample_clk;
    logic signed [W-1:0] sample_in0;
    logic signed [W-1:0] sample_in1;
    logic signed [W-1:0] sample_in2;
    logic signed [W-1:0] sample_in3;
    logic signed [W-1:0] sample_out0;
    logic signed [W-1:0] sample_out1;
    logic signed [W-1:0] sample_out2;
    logic signed [W-1:0] sample_out3;
    logic [7:0]          jack;

    modport master (
        output sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack,
        input  sample_out0, sample_out1, sample_out2, sample_out3
    );

    modport slave (
        input  sample_clk, sample_in0, sample_in1, sample_in2, sample_in3, jack,
        output sample_out0, sample_out1, sample_out2, sample_out3
    );

endinterface

// File: rtl/sample_rate_reducer_edge_detect.sv
// Rising-edge pulse for a strobe synchronous to clk; one pulse per rise however long the strobe stays high.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse_c
);

    logic strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign pulse_c = strobe & ~strobe_q;

endmodule

// File: rtl/sample_rate_reducer.sv
// Sample-and-hold downsampler: channels 1-3 are re-sampled every P sample_clk ticks, P set by the CV on channel 0.
module sample_rate_reducer
    import sample_rate_reducer_pkg::*;
#(
    parameter int unsigned W      = SAMPLE_W,
    parameter int unsigned PSHIFT = DEF_PSHIFT,
    parameter int unsigned PMAX   = DEF_PMAX,
    parameter int unsigned CV_MAX = CV_MAX_COUNTS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sample_rate_reducer_if.slave  bus
);

    localparam int unsigned CW = $clog2(PMAX + 1);
    localparam logic signed [W-1:0] CV_LIM = W'(CV_MAX);

    logic          tick_c;
    logic [W-1:0]  cv_c;
    logic          patched_c;
    int unsigned   p_idx_c;
    logic [CW-1:0] p_next_c;
    srr_state_e    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] period;

    strobe_edge_detect u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (bus.sample_clk),
        .pulse_c (tick_c)
    );

    // CV is chained through untouched
    assign bus.sample_out0 = bus.sample_in0;

    // Clamp CV to [0, CV_MAX], map to a hold period in [1, PMAX]; unpatched CV forces bypass
    always_comb begin
        cv_c      = '0;
        patched_c = (bus.jack & 8'h01) != 8'h00;
        if (bus.sample_in0[W-1]) begin
            cv_c = '0;
        end else if (bus.sample_in0 > CV_LIM) begin
            cv_c = W'(CV_LIM);
        end else begin
            cv_c = W'(bus.sample_in0);
        end
        p_idx_c = 32'd1 + (32'(cv_c) >> PSHIFT);
        if (p_idx_c > 32'(PMAX)) begin
            p_idx_c = 32'(PMAX);
        end
        if (!patched_c) begin
            p_idx_c = 32'd1;
        end
        p_next_c = CW'(p_idx_c);
    end

    // Period is only reloaded at capture, so a window in progress keeps its length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= HOLD;
            cnt             <= '0;
            period          <= CW'(1);
            bus.sample_out1 <= '0;
            bus.sample_out2 <= '0;
            bus.sample_out3 <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (tick_c) begin
                        if (cnt == period - CW'(1)) begin
                            state <= CAPTURE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                CAPTURE: begin
                    bus.sample_out1 <= bus.sample_in1;
                    bus.sample_out2 <= bus.sample_in2;
                    bus.sample_out3 <= bus.sample_in3;
                    period          <= p_next_c;
                    state           <= HOLD;
                    if (tick_c) begin
                        cnt <= CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_rate_reducer.sv
// Directed bench for sample_rate_reducer: reset, bypass, hold period mapping, window boundaries, long strobe, mid-run reset.
module tb_sample_rate_reducer;

    logic clk = 1'b0;
    logic rst_n;
    int   vec  = 0;
    int   errs = 0;

    sample_rate_reducer_if bus ();

    sample_rate_reducer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic pulse(input int hi);
        @(negedge clk);
        bus.sample_clk = 1'b1;
        repeat (hi) @(negedge clk);
        bus.sample_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        bus.sample_clk = 1'b0;
        bus.jack       = 8'h00;
        bus.sample_in0 = 16'sd0;
        bus.sample_in1 = 16'sd1234;
        bus.sample_in2 = -16'sd2;
        bus.sample_in3 = 16'sd7;
        #23;
        vec++; if (bus.sample_out1 !== 16'sd0) begin errs++; $display("FAIL reset_out1 got %0d want 0", bus.sample_out1); end
        vec++; if (bus.sample_out2 !== 16'sd0) begin errs++; $display("FAIL reset_out2 got %0d want 0", bus.sample_out2); end
        vec++; if (bus.sample_out3 !== 16'sd0) begin errs++; $display("FAIL reset_out3 got %0d want 0", bus.sample_out3); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vec++; if (bus.sample_out1 !== 16'sd0) begin errs++; $display("FAIL post_reset_idle got %0d want 0", bus.sample_out1); end
        bus.sample_in0 = 16'sh1357;
        #1;
        vec++; if (bus.sample_out0 !== 16'sh1357) begin errs++; $display("FAIL out0_mirror got %h want 1357", bus.sample_out0); end
        @(negedge clk);
        bus.sample_clk = 1'b1;
        @(posedge clk); #1;
        vec++; if (bus.sample_out1 !== 16'sd0) begin errs++; $display("FAIL first_tick_1clk got %0d want 0", bus.sample_out1); end
        @(posedge clk); #1;
        vec++; if (bus.sample_out1 !== 16'sd1234) begin errs++; $display("FAIL first_tick_2clk got %0d want 1234", bus.sample_out1); end
        vec++; if (bus.sample_out2 !== -16'sd2) begin errs++; $display("FAIL first_tick_out2 got %0d want -2", bus.sample_out2); end
        vec++; if (bus.sample_out3 !== 16'sd7) begin errs++; $display("FAIL first_tick_out3 got %0d want 7", bus.sample_out3); end
        @(negedge clk);
        bus.sample_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bypass;
        bus.jack       = 8'h00;
        bus.sample_in0 = 16'sd20000;
        for (int k = 1; k <= 10; k++) begin
            bus.sample_in1 = 16'(100 * k);
            pulse(1);
            vec++;
            if (bus.sample_out1 !== 16'(100 * k)) begin
                errs++; $display("FAIL bypass_%0d got %0d want %0d", k, bus.sample_out1, 100 * k);
            end
        end
    endtask

    task automatic test_hold;
        bus.jack       = 8'h01;
        bus.sample_in0 = 16'sd4096;
        for (int i = 0; i < 16; i++) begin
            bus.sample_in2 = 16'(i);
            pulse(1);
            vec++;
            if (bus.sample_out2 !== 16'((i / 5) * 5)) begin
                errs++; $display("FAIL hold_p5_pulse%0d got %0d want %0d", i, bus.sample_out2, (i / 5) * 5);
            end
        end
    endtask

    task automatic test_saturation;
        bus.sample_in0 = 16'sd32767;
        for (int i = 1; i <= 4; i++) begin
            bus.sample_in3 = 16'(100 + i);
            pulse(1);
        end
        vec++; if (bus.sample_out3 !== 16'sd7) begin errs++; $display("FAIL sat_old_window got %0d want 7", bus.sample_out3); end
        bus.sample_in3 = 16'sd200;
        pulse(1);
        vec++; if (bus.sample_out3 !== 16'sd200) begin errs++; $display("FAIL sat_boundary got %0d want 200", bus.sample_out3); end
        for (int i = 1; i <= 19; i++) begin
            bus.sample_in3 = 16'(300 + i);
            pulse(1);
            vec++;
            if (bus.sample_out3 !== 16'sd200) begin
                errs++; $display("FAIL sat_p20_hold%0d got %0d want 200", i, bus.sample_out3);
            end
        end
        bus.sample_in0 = -16'sd8000;
        bus.sample_in3 = 16'sd400;
        pulse(1);
        vec++; if (bus.sample_out3 !== 16'sd400) begin errs++; $display("FAIL sat_p20_capture got %0d want 400", bus.sample_out3); end
        for (int i = 1; i <= 2; i++) begin
            bus.sample_in3 = 16'(400 + i);
            pulse(1);
            vec++;
            if (bus.sample_out3 !== 16'(400 + i)) begin
                errs++; $display("FAIL neg_cv_p1_%0d got %0d want %0d", i, bus.sample_out3, 400 + i);
            end
        end
    endtask

    task automatic test_mid_window;
        bus.sample_in0 = 16'sd4096;
        bus.sample_in2 = 16'sd500;
        pulse(1);
        vec++; if (bus.sample_out2 !== 16'sd500) begin errs++; $display("FAIL midwin_start got %0d want 500", bus.sample_out2); end
        for (int i = 1; i <= 4; i++) begin
            if (i == 3) bus.sample_in0 = 16'sd0;
            bus.sample_in2 = 16'(500 + i);
            pulse(1);
            vec++;
            if (bus.sample_out2 !== 16'sd500) begin
                errs++; $display("FAIL midwin_hold%0d got %0d want 500", i, bus.sample_out2);
            end
        end
        for (int i = 5; i <= 7; i++) begin
            bus.sample_in2 = 16'(500 + i);
            pulse(1);
            vec++;
            if (bus.sample_out2 !== 16'(500 + i)) begin
                errs++; $display("FAIL midwin_after%0d got %0d want %0d", i, bus.sample_out2, 500 + i);
            end
        end
    endtask

    task automatic test_long_strobe;
        bus.sample_in0 = 16'sd4096;
        bus.sample_in1 = -16'sd300;
        pulse(1);
        vec++; if (bus.sample_out1 !== -16'sd300) begin errs++; $display("FAIL long_setup got %0d want -300", bus.sample_out1); end
        bus.sample_in1 = -16'sd301;
        pulse(50);
        vec++; if (bus.sample_out1 !== -16'sd300) begin errs++; $display("FAIL long_strobe got %0d want -300", bus.sample_out1); end
        for (int i = 2; i <= 4; i++) begin
            bus.sample_in1 = 16'(-300 - i);
            pulse(1);
            vec++;
            if (bus.sample_out1 !== -16'sd300) begin
                errs++; $display("FAIL long_hold%0d got %0d want -300", i, bus.sample_out1);
            end
        end
        bus.sample_in1 = -16'sd305;
        pulse(1);
        vec++; if (bus.sample_out1 !== -16'sd305) begin errs++; $display("FAIL long_capture got %0d want -305", bus.sample_out1); end
    endtask

    task automatic test_mid_reset;
        bus.sample_in1 = 16'sd50;
        pulse(1);
        vec++; if (bus.sample_out1 !== -16'sd305) begin errs++; $display("FAIL midrst_pre got %0d want -305", bus.sample_out1); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec++; if (bus.sample_out1 !== 16'sd0) begin errs++; $display("FAIL midrst_async_out1 got %0d want 0", bus.sample_out1); end
        vec++; if (bus.sample_out2 !== 16'sd0) begin errs++; $display("FAIL midrst_async_out2 got %0d want 0", bus.sample_out2); end
        vec++; if (bus.sample_out3 !== 16'sd0) begin errs++; $display("FAIL midrst_async_out3 got %0d want 0", bus.sample_out3); end
        #10;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.sample_in1 = 16'sd60;
        repeat (3) @(negedge clk);
        vec++; if (bus.sample_out1 !== 16'sd0) begin errs++; $display("FAIL midrst_idle got %0d want 0", bus.sample_out1); end
        pulse(1);
        vec++; if (bus.sample_out1 !== 16'sd60) begin errs++; $display("FAIL midrst_first_tick got %0d want 60", bus.sample_out1); end
        bus.sample_in1 = 16'sd61;
        pulse(1);
        vec++; if (bus.sample_out1 !== 16'sd60) begin errs++; $display("FAIL midrst_p5_hold got %0d want 60", bus.sample_out1); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_hold();
        test_saturation();
        test_mid_window();
        test_long_strobe();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/sample_rate_reducer.md
Name: sample_rate_reducer

Overview:
- Downsampling stage that sits directly downstream of the bit crusher.
- Holds each audio channel (1-3) for P sample periods, then re-samples it. P is set by the CV voltage on channel 0.
- Runs in the fast clk domain. It detects sample_clk edges internally so the hold counter and period update are fully synchronous.
- Channel 0 is passed through unchanged, so the CV can be chained to further stages.

Parameters:
W, 16, sample width (signed two's complement, 4 counts/mV)
PSHIFT, 10, right-shift applied to clamped CV to form period index
PMAX, 20, maximum hold period in samples (period saturates here)
CV_MAX, 20000, CV clamp ceiling (5 V)

Ports:
clk  in  1  system clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
sample_clk  in  1  audio-rate strobe, synchronous to clk, high for >=1 clk
sample_in0  in  W  signed CV: hold-period control
sample_in1  in  W  signed audio in
sample_in2  in  W  signed audio in
sample_in3  in  W  signed audio in
sample_out0  out  W  sample_in0 mirrored combinationally
sample_out1  out  W  held audio out
sample_out2  out  W  held audio out
sample_out3  out  W  held audio out
jack  in  8  jack-detect bits; jack[0]=1 means CV input patched

Behaviour:
- Reset (rst_n low, asynchronous):
  - sample_out1..3 = 0
  - hold counter = 0
  - period register = 1
  - sample_clk history flop = 0
- Edge detect: tick = sample_clk & ~sclk_q, where sclk_q is sample_clk registered on clk.
  - Exactly one tick per sample_clk rising edge.
  - sample_clk held high for many clk cycles still produces one tick.
- Period computation (combinational, evaluated at the moment of capture):
  - cv_c = 0 if sample_in0 < 0; CV_MAX if sample_in0 > CV_MAX; else sample_in0.
  - p_next = min(1 + (cv_c >> PSHIFT), PMAX).
  - If jack[0] == 0, p_next = 1 (bypass: output tracks input every sample).
- State machine, two states:
  - HOLD: on tick, if cnt == period-1:
    - go to CAPTURE
    - cnt <= 0
    - otherwise cnt <= cnt+1 and outputs unchanged.
  - CAPTURE (one clk):
    - sample_out1..3 <= sample_in1..3
    - period <= p_next
    - return to HOLD
- Latency: output updates 2 clk cycles after the qualifying sample_clk rising edge (1 edge-detect + 1 capture).
- Period changes only take effect at a capture boundary. A CV change mid-window never shortens or extends the window in progress.
- A tick arriving while in CAPTURE:
  - is counted: cnt becomes 1 on return to HOLD.
  - cannot occur in practice when sample_clk period >> 2 clk, but the behaviour is defined.
- Period = 1: every tick captures, so this is a pure 2-cycle-latency register stage.
- First capture after reset occurs on the first tick (period=1 at reset).
- Reset asserted mid-window aborts immediately. After release, outputs stay 0 until the first tick.
- cnt width = $clog2(PMAX+1). cnt never exceeds PMAX-1.
- No arithmetic on audio: samples are copied bit-exact, sign preserved.

Decomposition:
- Shared package (pmod_pkg, or the existing shared package):
  - sample width constant
  - mV-to-count scale (4)
  - CV_MAX (5 V = 20000) constant, shared with bit crusher thresholds
  - state enum typedef {HOLD, CAPTURE}
- One natural sub-module: strobe_edge_detect. Registered rising-edge pulse, async active-low reset; reusable by every sample_clk-driven core.
- Period mapping stays inline.

Test Plan:
- Reset:
  - stimulus: assert rst_n=0 with sample_in1=1234, then release; no sample_clk edges.
  - required: outputs 0.
  - then one sample_clk pulse -> sample_out1=1234 exactly 2 clk after the rising edge.
- Bypass:
  - stimulus: jack[0]=0, sample_in0=20000, 10 sample_clk pulses with sample_in1 = 100,200,...,1000.
  - required: sample_out1 follows every sample (period 1).
- Hold:
  - stimulus: jack[0]=1, sample_in0=4096 (p=5), ramp sample_in2 by +1 each sample_clk.
  - required: sample_out2 changes every 5th pulse, values 0, 5, 10, ...
- Saturation and negative CV:
  - stimulus: sample_in0=32767.
  - required: p=20 (clamped, then capped at PMAX).
  - stimulus: sample_in0=-8000.
  - required: p=1.
- Mid-window CV change:
  - stimulus: at p=5, change sample_in0 to 0 after the 2nd tick.
  - required: the current window still lasts 5 ticks; subsequent captures occur every tick.
- Long strobe and mid-run reset:
  - stimulus: hold sample_clk high for 50 clk.
  - required: counts as 1 tick.
  - stimulus: pulse rst_n low mid-window.
  - required: outputs 0 immediately, with no clk edge needed.
